// File: rtl/camera_pkg.sv
// Shared definitions for the camera line packetizer: header magic, FSM encoding,
// packet word layout and word-building helpers.
package camera_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned PIX_W   = 24;
  localparam int unsigned PAD_W   = 8;
  localparam int unsigned FIELD_W = 16;
  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DROP_W  = 16;

  localparam logic [FIELD_W-1:0] HDR_MAGIC = 16'hCA5E;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LINE = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // FIFO entry: packet word plus its delimiters (66 bits)
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [WORD_W-1:0] data;
  } fifo_word_t;

  function automatic fifo_word_t make_header(input logic [FRAME_W-1:0] fid,
                                             input logic [Y_W-1:0]     y,
                                             input logic [FIELD_W-1:0] width);
    fifo_word_t w;
    w.sop  = 1'b1;
    w.eop  = 1'b0;
    w.data = {HDR_MAGIC, fid, {(FIELD_W-Y_W){1'b0}}, y, width};
    return w;
  endfunction

  function automatic fifo_word_t make_data(input logic [PIX_W-1:0] p0,
                                           input logic [PIX_W-1:0] p1,
                                           input logic             eop);
    fifo_word_t w;
    w.sop  = 1'b0;
    w.eop  = eop;
    w.data = {{PAD_W{1'b0}}, p0, {PAD_W{1'b0}}, p1};
    return w;
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// First-word-fall-through synchronous FIFO carrying packet words with sop/eop.
module pkt_sync_fifo
  import camera_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fifo_word_t               push_word,
  input  logic                     pop,
  output fifo_word_t               head,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fifo_word_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // Head is forced to zero when empty so the stream outputs read as idle
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == (AW+1)'(DEPTH))));

endmodule

// File: rtl/camera_line_packetizer.sv
// Packs decoded RGB pixels of each video line into a header + data-word packet,
// reserving FIFO space at line start and dropping lines that do not fit.
module camera_line_packetizer
  import camera_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           pixel_r,
  input  logic [7:0]           pixel_g,
  input  logic [7:0]           pixel_b,
  input  logic [X_W-1:0]       pixel_x,
  input  logic [Y_W-1:0]       pixel_y,
  input  logic                 pixel_valid,
  input  logic                 frame_done,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [DROP_W-1:0]    line_drop_cnt,
  output logic                 seq_error
);

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PKT_WORDS = WIDTH / 2 + 1;
  localparam logic [X_W-1:0] LAST_X = X_W'(WIDTH - 1);

  logic [1:0]          state, state_nx;
  logic [X_W-1:0]      expected_x, expected_x_nx;
  logic [PIX_W-1:0]    hold, hold_nx;
  logic [DROP_W-1:0]   drop_cnt_nx;
  logic                seq_error_nx;
  logic [FRAME_W-1:0]  frame_id;

  logic                push;
  fifo_word_t          push_word;
  fifo_word_t          head;
  logic                fifo_not_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                room;
  logic [PIX_W-1:0]    pixel;

  assign pixel = {pixel_r, pixel_g, pixel_b};
  // A whole packet must fit before the header is committed
  assign room  = (fifo_count <= CNT_W'(FIFO_DEPTH - PKT_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      expected_x    <= '0;
      hold          <= '0;
      line_drop_cnt <= '0;
      seq_error     <= 1'b0;
      frame_id      <= '0;
    end else begin
      state         <= state_nx;
      expected_x    <= expected_x_nx;
      hold          <= hold_nx;
      line_drop_cnt <= drop_cnt_nx;
      seq_error     <= seq_error_nx;
      if (frame_done) frame_id <= frame_id + FRAME_W'(1);
    end
  end

  always_comb begin
    state_nx      = state;
    expected_x_nx = expected_x;
    hold_nx       = hold;
    drop_cnt_nx   = line_drop_cnt;
    seq_error_nx  = seq_error;
    push          = 1'b0;
    push_word     = '0;
    if (pixel_valid) begin
      case (state)
        ST_LINE: begin
          if (pixel_x == expected_x) begin
            expected_x_nx = pixel_x + X_W'(1);
            if (!pixel_x[0]) begin
              hold_nx = pixel;
            end else begin
              push      = 1'b1;
              push_word = make_data(hold, pixel, pixel_x == LAST_X);
              if (pixel_x == LAST_X) state_nx = ST_IDLE;
            end
          end else begin
            // Close the broken line so downstream still sees a terminated packet
            seq_error_nx = 1'b1;
            push         = 1'b1;
            push_word    = make_data(hold, '0, 1'b1);
            state_nx     = ST_IDLE;
          end
        end
        default: begin
          // IDLE and DROP both resynchronise on x=0
          if (pixel_x == '0) begin
            if (room) begin
              push          = 1'b1;
              push_word     = make_header(frame_id, pixel_y, FIELD_W'(WIDTH));
              hold_nx       = pixel;
              expected_x_nx = X_W'(1);
              state_nx      = ST_LINE;
            end else begin
              if (line_drop_cnt != '1) drop_cnt_nx = line_drop_cnt + DROP_W'(1);
              state_nx = ST_DROP;
            end
          end else if (state != ST_DROP) begin
            seq_error_nx = 1'b1;
          end
        end
      endcase
    end
  end

  pkt_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (out_ready),
    .head      (head),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign out_valid = fifo_not_empty;
  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;

endmodule

// File: tb/tb_camera_line_packetizer.sv
// Directed bench for camera_line_packetizer: builds expected packet words from
// the pixel pattern it drives and compares them with the captured output stream.
module tb_camera_line_packetizer;

  localparam int unsigned W = 640;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pixel_r = '0, pixel_g = '0, pixel_b = '0;
  logic [9:0]  pixel_x = '0;
  logic [8:0]  pixel_y = '0;
  logic        pixel_valid = 1'b0;
  logic        frame_done = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] line_drop_cnt;
  logic        seq_error;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [65:0] exp_q[$];
  logic [65:0] rx_q[$];
  logic [7:0]  line_g = 8'h01;
  logic [7:0]  line_b = 8'h02;
  bit          rnd_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [65:0] stall_word = '0;

  camera_line_packetizer #(.WIDTH(W), .FIFO_DEPTH(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_r       (pixel_r),
    .pixel_g       (pixel_g),
    .pixel_b       (pixel_b),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_valid   (pixel_valid),
    .frame_done    (frame_done),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .line_drop_cnt (line_drop_cnt),
    .seq_error     (seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Capture transfers and check stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 66'(out_valid), 66'd1);
        chk("stall_word", {out_sop, out_eop, out_data}, stall_word);
      end
      if (out_valid && out_ready) rx_q.push_back({out_sop, out_eop, out_data});
      stall_prev = out_valid && !out_ready;
      stall_word = {out_sop, out_eop, out_data};
    end
  end

  function automatic logic [23:0] rgb(input int x);
    return {8'(x), line_g, line_b};
  endfunction

  function automatic logic [65:0] exp_hdr(input logic [15:0] fid, input int y);
    return {1'b1, 1'b0, 16'hCA5E, fid, 7'd0, 9'(y), 16'(W)};
  endfunction

  function automatic logic [65:0] exp_dat(input logic [23:0] p0, input logic [23:0] p1,
                                          input logic eop);
    return {1'b0, eop, 8'h00, p0, 8'h00, p1};
  endfunction

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    repeat (n) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_pix(input int x, input int y, input logic fd);
    pixel_valid = 1'b1;
    pixel_x     = 10'(x);
    pixel_y     = 9'(y);
    {pixel_r, pixel_g, pixel_b} = rgb(x);
    frame_done  = fd;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
  endtask

  task automatic expect_line(input int y, input logic [15:0] fid);
    exp_q.push_back(exp_hdr(fid, y));
    for (int i = 0; i < int'(W / 2); i++)
      exp_q.push_back(exp_dat(rgb(2 * i), rgb(2 * i + 1), i == int'(W / 2) - 1));
  endtask

  task automatic send_line(input int y, input logic fd_first, input bit accept,
                           input logic [15:0] fid);
    if (accept) expect_line(y, fid);
    for (int x = 0; x < int'(W); x++) drive_pix(x, y, (x == 0) && fd_first);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    if (!rnd_ready) out_ready = 1'b1;
    while (rx_q.size() < exp_q.size() && guard < 20000) begin
      idle(1);
      guard++;
    end
    idle(4);
    chk({tag, "_count"}, 66'(rx_q.size()), 66'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [65:0] w;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 66'(out_valid), 66'd0);
    chk("rst_sop", 66'(out_sop), 66'd0);
    chk("rst_eop", 66'(out_eop), 66'd0);
    chk("rst_data", 66'(out_data), 66'd0);
    chk("rst_drops", 66'(line_drop_cnt), 66'd0);
    chk("rst_seqerr", 66'(seq_error), 66'd0);
    rst = 1'b0;
    idle(2);

    // One full line, free-flowing output
    out_ready = 1'b1;
    send_line(5, 1'b0, 1'b1, 16'h0000);
    drain("line5");
    w = (rx_q.size() > 0) ? rx_q[0] : '0;
    chk("hdr_literal", 66'(w[63:0]), 66'h0000_CA5E_0000_0005_0280);
    chk("line5_drops", 66'(line_drop_cnt), 66'd0);
    clear_q();

    // Stalled output: three lines fit, the fourth is dropped
    out_ready = 1'b0;
    send_line(0, 1'b0, 1'b1, 16'h0000);
    send_line(1, 1'b0, 1'b1, 16'h0000);
    send_line(2, 1'b0, 1'b1, 16'h0000);
    send_line(3, 1'b0, 1'b0, 16'h0000);
    idle(2);
    chk("stall_drops", 66'(line_drop_cnt), 66'd1);
    chk("stall_seqerr", 66'(seq_error), 66'd0);
    drain("stall3");
    chk("stall3_total", 66'(rx_q.size()), 66'd963);
    clear_q();

    // Coordinate jump 10 -> 12 terminates the packet at the word holding x=10
    out_ready = 1'b1;
    exp_q.push_back(exp_hdr(16'h0000, 7));
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_dat(rgb(2 * i), rgb(2 * i + 1), 1'b0));
    exp_q.push_back(exp_dat(rgb(10), 24'h0, 1'b1));
    for (int x = 0; x <= 10; x++) drive_pix(x, 7, 1'b0);
    for (int x = 12; x < int'(W); x++) drive_pix(x, 7, 1'b0);
    idle(2);
    chk("jump_seqerr", 66'(seq_error), 66'd1);
    send_line(8, 1'b0, 1'b1, 16'h0000);
    drain("jump");
    clear_q();

    // Two frame_done pulses advance the header frame_id to 2
    frame_done = 1'b1; @(posedge clk); #1; frame_done = 1'b0;
    idle(3);
    frame_done = 1'b1; @(posedge clk); #1; frame_done = 1'b0;
    idle(3);
    send_line(9, 1'b0, 1'b1, 16'h0002);
    drain("fid2");
    clear_q();

    // 65534 more pulses wrap frame_id to 0; a header pushed with frame_done uses the old value
    frame_done = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    frame_done = 1'b0;
    send_line(10, 1'b1, 1'b1, 16'h0000);
    send_line(11, 1'b0, 1'b1, 16'h0001);
    drain("fidwrap");
    clear_q();

    // Random 50% backpressure with a different colour pattern
    line_g = 8'hA5;
    line_b = 8'h3C;
    rnd_ready = 1'b1;
    send_line(12, 1'b0, 1'b1, 16'h0001);
    send_line(13, 1'b0, 1'b1, 16'h0001);
    drain("random");
    rnd_ready = 1'b0;
    chk("random_drops", 66'(line_drop_cnt), 66'd1);
    clear_q();

    // Reset in the middle of a line discards everything buffered
    line_g = 8'h01;
    line_b = 8'h02;
    out_ready = 1'b0;
    for (int x = 0; x < 100; x++) drive_pix(x, 14, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 66'(out_valid), 66'd0);
    chk("midrst_data", 66'(out_data), 66'd0);
    chk("midrst_drops", 66'(line_drop_cnt), 66'd0);
    chk("midrst_seqerr", 66'(seq_error), 66'd0);
    clear_q();
    rst = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("postrst_valid", 66'(out_valid), 66'd0);
    send_line(15, 1'b0, 1'b1, 16'h0000);
    drain("postrst");
    clear_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/camera_line_packetizer.md
CAMERA_LINE_PACKETIZER -- requirements
Module: camera_line_packetizer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per line (even, ≤1023).
REQ-002 SHALL have parameter FIFO_DEPTH, default 1024, output FIFO depth in 64-bit words (power of 2, ≥ WIDTH/2+1).
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have ports pixel_r/pixel_g/pixel_b, input, 8 each: decoded RGB pixel.
REQ-006 SHALL have ports pixel_x, input, 10, and pixel_y, input, 9: pixel coordinates.
REQ-007 SHALL have port pixel_valid, input, 1: pixel qualifier; the upstream decoder has no backpressure.
REQ-008 SHALL have port frame_done, input, 1: end-of-frame pulse.
REQ-009 SHALL have port out_data, output, 64: packet word.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sop (output, 1), out_eop (output, 1): valid/ready stream with packet delimiters.
REQ-011 SHALL have ports line_drop_cnt (output, 16: lines dropped, saturating) and seq_error (output, 1: sticky coordinate error).

Function
REQ-012 SHALL emit one packet per accepted line: 1 header word, then WIDTH/2 data words.
REQ-013 Header word SHALL be [63:48]=16'hCA5E, [47:32]=frame_id, [31:16]={7'b0,pixel_y}, [15:0]=WIDTH; out_sop=1 on the header only.
REQ-014 Data word SHALL be [63:56]=0, [55:32]={R,G,B} of even x, [31:24]=0, [23:0]={R,G,B} of x+1; out_eop=1 on the word holding x=WIDTH-1 only.
REQ-015 The FSM SHALL have states IDLE, LINE and DROP, with at most one FIFO push per cycle.
REQ-016 In IDLE on pixel_valid with x=0: if FIFO free ≥ WIDTH/2+1, push the header, latch pixel 0 into the hold register, set expected_x=1 and go to LINE; otherwise increment line_drop_cnt (saturate at 16'hFFFF) and go to DROP.
REQ-017 In IDLE on pixel_valid with x≠0: set seq_error and stay in IDLE.
REQ-018 In LINE on pixel_valid with x=expected_x: an even x latches the hold register; an odd x pushes a data word; x=WIDTH-1 pushes with eop and returns to IDLE.
REQ-019 In LINE on pixel_valid with x≠expected_x: set seq_error, push {hold, zero pixel} with eop, and go to IDLE. A mismatching x=0 SHALL then be handled as REQ-016 on the next valid pixel.
REQ-020 In DROP, pixels SHALL be discarded until a pixel_valid with x=0, which SHALL be evaluated as in IDLE in that same cycle.
REQ-021 Because space is reserved at line start, the FIFO SHALL never overflow; a push when full is a design error that assertions flag.
REQ-022 frame_id (16 bit) SHALL increment, wrapping, on each cycle with frame_done=1; a header pushed in the same cycle uses the pre-increment value.
REQ-023 The FIFO SHALL be first-word-fall-through: a pushed word is visible on out_valid no earlier than the following cycle. A word transfers when out_valid&&out_ready.
REQ-024 out_data, out_sop and out_eop SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous push and pop SHALL both occur; free-space evaluation uses the pre-edge occupancy.

Reset
REQ-026 On rst: FSM=IDLE, FIFO empty, out_valid=0, out_sop=0, out_eop=0, out_data=0, frame_id=0, line_drop_cnt=0, seq_error=0, expected_x=0, hold register=0.
REQ-027 Reset mid-packet SHALL discard all buffered words with no partial emission after release.

Structure
REQ-028 The header magic 16'hCA5E, the state enum and the word field widths SHALL live in shared package camera_pkg.
REQ-029 The FIFO SHALL be the sub-module pkt_sync_fifo (66 bits wide: data+sop+eop, parameterised depth, count output).

Verification
REQ-030 One full line (y=5, frame_id=0, pixels R=x[7:0], G=1, B=2) with out_ready=1 -> 321 words; header 0xCA5E_0000_0005_0280; last word eop; 0 drops.
REQ-031 out_ready=0 for 3 lines, then 1 -> lines 0-2 are emitted intact (963 words total); line 3 is dropped; line_drop_cnt=1.
REQ-032 x jumps 10→12 -> seq_error=1; the packet ends at the word holding x=10 with eop; the next x=0 line is emitted normally.
REQ-033 frame_done pulsed twice, then a line -> header [47:32]=0x0002; 65536 pulses -> frame_id wraps to 0.
REQ-034 out_ready toggled randomly at 50% -> the byte stream matches the reference model and data is stable under stall.
REQ-035 rst asserted after 100 pixels of a line -> out_valid=0 next cycle; after release, the next packet starts with sop and frame_id=0.
